// File: rtl/level_outcome_detector_if.sv
// Signal bundle between the collision/controller side (master) and the level referee (slave).
// Carries per-frame judging inputs and the latched outcome levels.
interface level_outcome_detector_if #(
   parameter int TIME_LIMIT_SEC = 120
);
   localparam int W = $clog2(TIME_LIMIT_SEC + 1);

   logic         frame_tick;
   logic         revive;
   logic [1:0]   fb_tile;
   logic [1:0]   ig_tile;
   logic         fb_at_door;
   logic         ig_at_door;
   logic         gameover;
   logic         gamewin;
   logic [1:0]   death_cause;
   logic [W-1:0] time_left;

   modport master (
      output frame_tick, revive, fb_tile, ig_tile, fb_at_door, ig_at_door,
      input  gameover, gamewin, death_cause, time_left
   );

   modport slave (
      input  frame_tick, revive, fb_tile, ig_tile, fb_at_door, ig_at_door,
      output gameover, gamewin, death_cause, time_left
   );
endinterface

// File: rtl/level_outcome_detector.sv
// Per-frame level referee: hazard deaths, door-hold win and level time-out with latched results.
// Define OUTCOME_TIMER_EN to build the frame/second time-limit logic; otherwise time_left is constant.
module level_outcome_detector #(
   parameter int FRAMES_PER_SEC   = 60,
   parameter int TIME_LIMIT_SEC   = 120,
   parameter int DOOR_HOLD_FRAMES = 30
) (
   input  logic                     Clk,
   input  logic                     Reset,
   level_outcome_detector_if.slave  bus
);
   localparam int W  = $clog2(TIME_LIMIT_SEC + 1);
   localparam int DW = $clog2(DOOR_HOLD_FRAMES + 1);

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_FIREBOY = 2'b01;
   localparam logic [1:0] CAUSE_ICEGIRL = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, PLAYING, LOST, WON} state_t;

   state_t        state, state_nxt;
   logic          gameover_q, gameover_nxt;
   logic          gamewin_q, gamewin_nxt;
   logic [1:0]    cause_q, cause_nxt;
   logic [DW-1:0] door_cnt, door_nxt;

   logic fb_death, ig_death, both_at_door, timeout, judge;

   assign judge        = (state == PLAYING) && bus.frame_tick && !bus.revive;
   assign fb_death     = (bus.fb_tile == 2'b10) || (bus.fb_tile == 2'b11);
   assign ig_death     = (bus.ig_tile == 2'b01) || (bus.ig_tile == 2'b11);
   assign both_at_door = bus.fb_at_door && bus.ig_at_door;

`ifdef OUTCOME_TIMER_EN
   localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

   logic [FW-1:0] frame_cnt, frame_nxt;
   logic [W-1:0]  time_left_q, time_left_nxt;
   logic          second_wrap;

   assign second_wrap = (frame_cnt == FW'(FRAMES_PER_SEC - 1));

   always_comb begin
      frame_nxt     = frame_cnt;
      time_left_nxt = time_left_q;
      timeout       = 1'b0;
      if (bus.revive) begin
         frame_nxt     = '0;
         time_left_nxt = W'(TIME_LIMIT_SEC);
      end else if (judge) begin
         frame_nxt = second_wrap ? '0 : frame_cnt + 1'b1;
         if (second_wrap && (time_left_q != '0)) begin
            time_left_nxt = time_left_q - 1'b1;
            timeout       = (time_left_q == W'(1));
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt   <= '0;
         time_left_q <= W'(TIME_LIMIT_SEC);
      end else begin
         frame_cnt   <= frame_nxt;
         time_left_q <= time_left_nxt;
      end
   end

   assign bus.time_left = time_left_q;
`else
   logic [31:0] unused_frames_per_sec;

   assign unused_frames_per_sec = FRAMES_PER_SEC;
   assign timeout               = 1'b0;
   assign bus.time_left         = W'(TIME_LIMIT_SEC);
`endif

   // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_nxt    = state;
      gameover_nxt = gameover_q;
      gamewin_nxt  = gamewin_q;
      cause_nxt    = cause_q;
      door_nxt     = door_cnt;
      if (bus.revive) begin
         state_nxt    = PLAYING;
         gameover_nxt = 1'b0;
         gamewin_nxt  = 1'b0;
         cause_nxt    = CAUSE_NONE;
         door_nxt     = '0;
      end else if (judge) begin
         if (!both_at_door)
            door_nxt = '0;
         else if (door_cnt != DW'(DOOR_HOLD_FRAMES))
            door_nxt = door_cnt + 1'b1;

         // Loss beats win; among losses Fireboy outranks Icegirl outranks the clock.
         if (fb_death || ig_death || timeout) begin
            state_nxt    = LOST;
            gameover_nxt = 1'b1;
            cause_nxt    = fb_death ? CAUSE_FIREBOY :
                           ig_death ? CAUSE_ICEGIRL : CAUSE_TIMEOUT;
         end else if (door_nxt == DW'(DOOR_HOLD_FRAMES)) begin
            state_nxt   = WON;
            gamewin_nxt = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         gameover_q <= 1'b0;
         gamewin_q  <= 1'b0;
         cause_q    <= CAUSE_NONE;
         door_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         gameover_q <= gameover_nxt;
         gamewin_q  <= gamewin_nxt;
         cause_q    <= cause_nxt;
         door_cnt   <= door_nxt;
      end
   end

   assign bus.gameover    = gameover_q;
   assign bus.gamewin     = gamewin_q;
   assign bus.death_cause = cause_q;
endmodule

// File: tb/tb_level_outcome_detector.sv
// Directed bench for level_outcome_detector; expectations follow OUTCOME_TIMER_EN when it is defined.
module tb_level_outcome_detector;
   localparam int FPS  = 60;
   localparam int TLIM = 120;
   localparam int HOLD = 30;
`ifdef OUTCOME_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clk = ~Clk;

   level_outcome_detector_if #(.TIME_LIMIT_SEC(TLIM)) bus ();

   level_outcome_detector #(
      .FRAMES_PER_SEC(FPS), .TIME_LIMIT_SEC(TLIM), .DOOR_HOLD_FRAMES(HOLD)
   ) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic check_out(input string tag, input logic go, input logic gw,
                            input logic [1:0] cause, input int tl);
      check({tag, ".gameover"},    32'(bus.gameover),    32'(go));
      check({tag, ".gamewin"},     32'(bus.gamewin),     32'(gw));
      check({tag, ".death_cause"}, 32'(bus.death_cause), 32'(cause));
      check({tag, ".time_left"},   32'(bus.time_left),   32'(tl));
   endtask

   // One stimulus cycle driven at a falling edge; outputs are stable at the following falling edge.
   task automatic drive(input logic tick, input logic rev, input logic [1:0] fb, input logic [1:0] ig,
                        input logic fd, input logic id);
      @(negedge Clk);
      bus.frame_tick = tick;
      bus.revive     = rev;
      bus.fb_tile    = fb;
      bus.ig_tile    = ig;
      bus.fb_at_door = fd;
      bus.ig_at_door = id;
      @(negedge Clk);
      bus.frame_tick = 1'b0;
      bus.revive     = 1'b0;
   endtask

   task automatic tick(input logic [1:0] fb, input logic [1:0] ig, input logic fd, input logic id);
      drive(1'b1, 1'b0, fb, ig, fd, id);
   endtask

   task automatic revive();
      drive(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
   endtask

   initial begin
      Reset          = 1'b1;
      bus.frame_tick = 1'b0;
      bus.revive     = 1'b0;
      bus.fb_tile    = 2'b00;
      bus.ig_tile    = 2'b00;
      bus.fb_at_door = 1'b0;
      bus.ig_at_door = 1'b0;
      repeat (3) @(negedge Clk);
      check_out("reset", 1'b0, 1'b0, 2'b00, TLIM);
      Reset = 1'b0;

      // Ticks in IDLE are ignored even with hazards and doors.
      repeat (3) tick(2'b10, 2'b01, 1'b1, 1'b1);
      check_out("idle", 1'b0, 1'b0, 2'b00, TLIM);

      // Fireboy hazard: lava is safe for him, water kills.
      revive();
      check_out("revive1", 1'b0, 1'b0, 2'b00, TLIM);
      repeat (5) tick(2'b00, 2'b00, 1'b0, 1'b0);
      tick(2'b01, 2'b00, 1'b0, 1'b0);
      check("fb_lava_safe", 32'(bus.gameover), 32'd0);
      tick(2'b10, 2'b00, 1'b0, 1'b0);
      check_out("fb_water", 1'b1, 1'b0, 2'b01, TLIM);
      tick(2'b00, 2'b11, 1'b1, 1'b1);
      tick(2'b00, 2'b01, 1'b0, 1'b0);
      check_out("lost_hold", 1'b1, 1'b0, 2'b01, TLIM);

      // Door hold: interrupted run of 29, then 30 consecutive ticks.
      revive();
      check_out("revive2", 1'b0, 1'b0, 2'b00, TLIM);
      repeat (29) tick(2'b00, 2'b00, 1'b1, 1'b1);
      check("door_29", 32'(bus.gamewin), 32'd0);
      tick(2'b00, 2'b00, 1'b1, 1'b0);
      check("door_break", 32'(bus.gamewin), 32'd0);
      repeat (29) tick(2'b00, 2'b00, 1'b1, 1'b1);
      check("door_29b", 32'(bus.gamewin), 32'd0);
      tick(2'b00, 2'b00, 1'b1, 1'b1);
      check_out("door_win", 1'b0, 1'b1, 2'b00, TLIM);
      tick(2'b11, 2'b11, 1'b0, 1'b0);
      check_out("won_hold", 1'b0, 1'b1, 2'b00, TLIM);

      // Death on the same tick the door count would complete.
      revive();
      repeat (29) tick(2'b00, 2'b00, 1'b1, 1'b1);
      tick(2'b00, 2'b01, 1'b1, 1'b1);
      check_out("ig_vs_win", 1'b1, 1'b0, 2'b10, TLIM);

      // Hazard priority: both die on one tick.
      revive();
      tick(2'b11, 2'b11, 1'b0, 1'b0);
      check_out("both_die", 1'b1, 1'b0, 2'b01, TLIM);
      revive();
      tick(2'b01, 2'b11, 1'b0, 1'b0);
      check_out("ig_goo", 1'b1, 1'b0, 2'b10, TLIM);

      // Revive coinciding with a tick clears the door counter and ignores the tick.
      revive();
      repeat (29) tick(2'b00, 2'b00, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
      check_out("rev_tick", 1'b0, 1'b0, 2'b00, TLIM);
      repeat (29) tick(2'b00, 2'b00, 1'b1, 1'b1);
      check("rev_door_29", 32'(bus.gamewin), 32'd0);
      tick(2'b00, 2'b00, 1'b1, 1'b1);
      check("rev_door_30", 32'(bus.gamewin), 32'd1);

      // Full level clock; doors held for the final 30 ticks so time-out and win coincide.
      revive();
      for (int i = 1; i <= FPS * TLIM; i++) begin
         tick(2'b00, 2'b00, i > FPS * TLIM - HOLD, i > FPS * TLIM - HOLD);
         if (i == FPS - 1)
            check("pre_wrap", 32'(bus.time_left), 32'(TLIM));
         if (i % FPS == 0) begin
            check($sformatf("sec%0d.time_left", i / FPS), 32'(bus.time_left),
                  TIMER ? 32'(TLIM - i / FPS) : 32'(TLIM));
            check($sformatf("sec%0d.gameover", i / FPS), 32'(bus.gameover),
                  32'(TIMER && i == FPS * TLIM));
            check($sformatf("sec%0d.gamewin", i / FPS), 32'(bus.gamewin),
                  32'(!TIMER && i == FPS * TLIM));
            check($sformatf("sec%0d.cause", i / FPS), 32'(bus.death_cause),
                  (TIMER && i == FPS * TLIM) ? 32'd3 : 32'd0);
         end
      end

`ifdef OUTCOME_TIMER_EN
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      check_out("timeout_hold", 1'b1, 1'b0, 2'b11, 0);

      // Mid-level revive with 50 s left and a same-cycle tick restarts both counters.
      revive();
      repeat (FPS * (TLIM - 50)) tick(2'b00, 2'b00, 1'b0, 1'b0);
      check("at_50", 32'(bus.time_left), 32'd50);
      drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      check_out("rev_at_50", 1'b0, 1'b0, 2'b00, TLIM);
      repeat (FPS - 1) tick(2'b00, 2'b00, 1'b0, 1'b0);
      check("rev_frame_59", 32'(bus.time_left), 32'(TLIM));
      tick(2'b00, 2'b00, 1'b0, 1'b0);
      check("rev_frame_60", 32'(bus.time_left), 32'(TLIM - 1));
`else
      revive();
      check_out("notimer_revive", 1'b0, 1'b0, 2'b00, TLIM);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
